// File: rtl/data_mem_if.sv
// Data-memory stage bus: M-stage request from the EX/MEM register and the
// W-stage writeback outputs toward the register file.
interface data_mem_if;
  logic [31:0] alu_resultM;
  logic [31:0] write_dataM;
  logic [2:0]  funct3M;
  logic        mem_readM;
  logic        mem_writeM;
  logic        reg_writeM;
  logic [4:0]  RdM;
  logic [31:0] PC_plus4M;
  logic [1:0]  result_srcM;
  logic        stallM;
  logic [31:0] resultW;
  logic [4:0]  RdW;
  logic        reg_writeW;
  logic        misalignW;

  modport master (
    output alu_resultM, write_dataM, funct3M, mem_readM, mem_writeM,
           reg_writeM, RdM, PC_plus4M, result_srcM,
    input  stallM, resultW, RdW, reg_writeW, misalignW
  );

  modport slave (
    input  alu_resultM, write_dataM, funct3M, mem_readM, mem_writeM,
           reg_writeM, RdM, PC_plus4M, result_srcM,
    output stallM, resultW, RdW, reg_writeW, misalignW
  );
endinterface

// File: rtl/data_mem_stage.sv
// MEM stage with byte-enabled data memory, extended loads, wait-state stall FSM
// and MEM/WB register. Optional misalign trap: define DMEM_MISALIGN_TRAP_EN.
module data_mem_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [AW-1:0] w_word_idx;
  logic [1:0]    w_lane;
  logic          w_is_byte, w_is_half, w_access, w_misalign;

  assign w_word_idx = bus.alu_resultM[AW+1:2];
  assign w_lane     = bus.alu_resultM[1:0];
  assign w_is_byte  = (bus.funct3M[1:0] == 2'b00);
  assign w_is_half  = (bus.funct3M[1:0] == 2'b01);
  assign w_access   = bus.mem_readM | bus.mem_writeM;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = w_access & ((w_is_half & w_lane[0]) |
                                  (!w_is_byte & !w_is_half & (w_lane != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misalign && (WAIT_STATES != 0)) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 3'd0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.stallM = w_stall & rst_n;

  // Store lane steering: data is replicated so each enabled lane sees its bytes.
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mem_we;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.write_dataM;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_lane;
      w_wdata = {4{bus.write_dataM[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{bus.write_dataM[15:0]}};
    end
  end

  assign w_mem_we = bus.mem_writeM & !w_stall & !w_misalign & rst_n;

  logic [3:0][7:0] r_mem [DEPTH_WORDS];

  // NOTE: the memory array is deliberately not reset; only control and W registers are.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_word_idx][i] <= w_wdata[8*i +: 8];
      end
    end
  end

  logic [31:0] w_rword, w_load_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_rword = r_mem[w_word_idx];
  assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
  assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load_ext = w_rword;
    if (w_is_byte)
      w_load_ext = bus.funct3M[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
    else if (w_is_half)
      w_load_ext = bus.funct3M[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
  end

  logic [XLEN-1:0] r_alu_w, r_load_w, r_pc4_w, w_result;
  logic [1:0]      r_result_src_w;
  logic [4:0]      r_rd_w;
  logic            r_reg_write_w;

  // Stall edges inject a bubble; data registers hold so resultW stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_w        <= '0;
      r_load_w       <= '0;
      r_pc4_w        <= '0;
      r_result_src_w <= 2'b00;
      r_rd_w         <= 5'd0;
      r_reg_write_w  <= 1'b0;
    end else if (w_stall) begin
      r_rd_w        <= 5'd0;
      r_reg_write_w <= 1'b0;
    end else begin
      r_alu_w        <= bus.alu_resultM;
      r_load_w       <= w_load_ext;
      r_pc4_w        <= bus.PC_plus4M;
      r_result_src_w <= bus.result_srcM;
      r_rd_w         <= bus.RdM;
      r_reg_write_w  <= bus.reg_writeM & !w_misalign;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign_w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_misalign_w <= 1'b0;
    else if (w_stall) r_misalign_w <= 1'b0;
    else              r_misalign_w <= w_misalign;
  end
  assign bus.misalignW = r_misalign_w;
`else
  assign bus.misalignW = 1'b0;
`endif

  always_comb begin
    w_result = '0;
    case (r_result_src_w)
      2'b00:   w_result = r_alu_w;
      2'b01:   w_result = r_load_w;
      2'b10:   w_result = r_pc4_w;
      default: w_result = '0;
    endcase
  end

  assign bus.resultW    = w_result;
  assign bus.RdW        = r_rd_w;
  assign bus.reg_writeW = r_reg_write_w;
endmodule
